// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

    // Default operand width
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, never less than 1 so the bit counter is always at least one bit wide
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Three-state controller for seq_mul: sequences load, per-bit step and finish strobes.
module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mb_last,   // multiplier magnitude becomes zero after this shift
    input  logic cnt_last,  // bit counter is at its final position
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    state_t state_q;
    logic   calc_exit;

    assign calc_exit = mb_last | cnt_last;

    // Datapath strobes decoded from the current state
    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state_q)
            IDLE: load = start;
            CALC: begin
                step   = 1'b1;
                finish = calc_exit;
            end
            default: ;
        endcase
    end

    // State register with registered busy/done so outputs never see input paths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= CALC;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    if (calc_exit) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_mul.sv
// Sequential signed/unsigned multiplier: magnitude shift-and-add with early termination
// once the remaining multiplier bits are all zero, sign applied on the final edge.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CNT_W = clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [PW-1:0]    ONE_P   = PW'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] ma_q;
    logic [WIDTH-1:0] mb_q;
    logic [PW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_sum;
    logic             mb_last;
    logic             cnt_last;
    logic             load;
    logic             step;
    logic             finish;

    seq_mul_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mb_last  (mb_last),
        .cnt_last (cnt_last),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .busy     (busy),
        .done     (done)
    );

    // Operand magnitudes, partial-product addend and termination status
    always_comb begin
        // Unsigned WIDTH-bit magnitude, so the most negative value maps to 2^(WIDTH-1)
        a_mag    = (sgn && a[WIDTH-1]) ? (~a + ONE_W) : a;
        b_mag    = (sgn && b[WIDTH-1]) ? (~b + ONE_W) : b;
        addend   = {{WIDTH{1'b0}}, ma_q} << cnt_q;
        acc_sum  = mb_q[0] ? (acc_q + addend) : acc_q;
        mb_last  = ((mb_q >> 1) == '0);
        cnt_last = (cnt_q == CNT_MAX);
    end

    // Multiplier datapath registers: load on accept, shift/accumulate each CALC edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q  <= '0;
            mb_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
        end else if (load) begin
            ma_q  <= a_mag;
            mb_q  <= b_mag;
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc_q <= acc_sum;
            mb_q  <= mb_q >> 1;
            cnt_q <= cnt_q + ONE_C;
        end
    end

    // Result register: captures the signed result on the final CALC edge and holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (finish) begin
            product <= neg_q ? (~acc_sum + ONE_P) : acc_sum;
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul (WIDTH=8): stimulus pushes expected results, a monitor
// pops and checks product, latency and busy length on every done pulse.
module tb_seq_mul;

    localparam int unsigned W = 8;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           sgn   = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    int cyc        = 0;
    int n_cmp      = 0;
    int n_bad      = 0;
    int busy_cnt   = 0;
    int dones_seen = 0;
    int issued     = 0;

    logic [2*W-1:0] q_prod[$];
    int             q_k[$];
    int             q_edge[$];
    string          q_name[$];

    string m_name;
    int    m_k;
    int    m_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2*W-1:0] p, input int k, input string name);
        q_prod.push_back(p);
        q_k.push_back(k);
        q_edge.push_back(cyc + 1);  // start is sampled on the next rising edge
        q_name.push_back(name);
        issued++;
    endtask

    task automatic issue(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [2*W-1:0] p, input int k, input string name);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        a     = ia;
        b     = ib;
        push_exp(p, k, name);
        @(negedge clk);
        start = 1'b0;
        sgn   = ~s;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/timeout: done not seen within 40 cycles", name);
            if (q_prod.size() != 0) begin
                void'(q_prod.pop_front());
                void'(q_k.pop_front());
                void'(q_edge.pop_front());
                void'(q_name.pop_front());
            end
        end
    endtask

    task automatic run(input logic s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2*W-1:0] p, input int k, input string name);
        issue(s, ia, ib, p, k, name);
        wait_done(name);
    endtask

    // Monitor: compare every done pulse against the oldest pending expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                dones_seen++;
                if (q_prod.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: product %0h with no pending operation", product);
                end else begin
                    m_name = q_name.pop_front();
                    m_k    = q_k.pop_front();
                    m_e    = q_edge.pop_front();
                    check({m_name, "/product"}, product, q_prod.pop_front());
                    check({m_name, "/latency"}, cyc - m_e, m_k);
                    check({m_name, "/busy_cycles"}, busy_cnt, m_k + 1);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/product", product, 0);
        #2 rst_n = 1'b1;

        run(1'b0, 8'd13, 8'd11, 16'h008F, 4, "u13x11");
        run(1'b1, 8'hF9, 8'h05, 16'hFFDD, 3, "s_m7x5");
        run(1'b0, 8'hF9, 8'h05, 16'h04DD, 3, "u249x5");
        run(1'b1, 8'h80, 8'h80, 16'h4000, 8, "s_min_x_min");
        run(1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "u255x255");
        run(1'b1, 8'h80, 8'h01, 16'hFF80, 1, "s_min_x1");
        run(1'b1, 8'hFF, 8'hFF, 16'h0001, 1, "s_m1xm1");
        run(1'b1, 8'h05, 8'hFD, 16'hFFF1, 2, "s_5xm3");
        run(1'b0, 8'h00, 8'h05, 16'h0000, 3, "a_zero");

        // b=0 then back-to-back start on the first IDLE cycle
        run(1'b0, 8'hFF, 8'h00, 16'h0000, 1, "b_zero");
        run(1'b0, 8'h02, 8'h03, 16'h0006, 2, "b2b_2x3");
        repeat (4) @(negedge clk);
        check("hold/product", product, 16'h0006);
        check("hold/busy", busy, 0);

        // start held and operands changed during CALC: only the edge-0 operands count
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        a     = 8'd13;
        b     = 8'd11;
        push_exp(16'h008F, 4, "held_start");
        repeat (3) begin
            @(negedge clk);
            sgn = 1'b1;
            a   = W'($urandom);
            b   = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("held_start");
        repeat (6) @(negedge clk);
        check("held_start/done_count", dones_seen, issued);

        // Reset two edges into a long run: outputs clear at once, no done afterwards
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset/busy", busy, 0);
        check("mid_reset/done", done, 0);
        check("mid_reset/product", product, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        // start on the very first edge after release
        start = 1'b1;
        sgn   = 1'b0;
        a     = 8'd3;
        b     = 8'd4;
        push_exp(16'h000C, 3, "after_reset_3x4");
        @(negedge clk);
        start = 1'b0;
        wait_done("after_reset_3x4");

        repeat (4) @(negedge clk);
        check("final/queue_empty", q_prod.size(), 0);
        check("final/done_count", dones_seen, issued);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
